// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_ctrl_pkg;

    localparam int unsigned StateBits = 5;

    typedef enum logic [StateBits-1:0] {
        StFetch   = 5'd0,
        StDecode  = 5'd1,
        StMemAdr  = 5'd2,
        StMemRd   = 5'd3,
        StMemWb   = 5'd4,
        StMemWr   = 5'd5,
        StRtypeEx = 5'd6,
        StRtypeWb = 5'd7,
        StBeqEx   = 5'd8,
        StBneEx   = 5'd9,
        StAddiEx  = 5'd10,
        StAndiEx  = 5'd11,
        StOriEx   = 5'd12,
        StSltiEx  = 5'd13,
        StIwb     = 5'd14,
        StJex     = 5'd15,
        StError   = 5'd31
    } state_e;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpLbu   = 6'b100100;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type function fields
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    // ALU operations
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    // ALU B-operand select
    localparam logic [2:0] SrcbB      = 3'b000;
    localparam logic [2:0] SrcbFour   = 3'b001;
    localparam logic [2:0] SrcbSimm   = 3'b010;
    localparam logic [2:0] SrcbSimmSh = 3'b011;
    localparam logic [2:0] SrcbZimm   = 3'b100;

    // PC source select
    localparam logic [1:0] PcsrcAluRes = 2'b00;
    localparam logic [1:0] PcsrcAluOut = 2'b01;
    localparam logic [1:0] PcsrcJump   = 2'b10;

    // Load extension
    localparam logic [1:0] LbWord  = 2'b00;
    localparam logic [1:0] LbSByte = 2'b01;
    localparam logic [1:0] LbZByte = 2'b10;

    // Unqualified control word; pcwrite/branch/irwrite/memwrite are gated in the top.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [2:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic [1:0] lb;
        logic       mem_req;
    } ctrl_t;

    function automatic state_e decode_op(input logic [5:0] op);
        case (op)
            OpLw, OpLb, OpLbu, OpSw: return StMemAdr;
            OpRtype:                 return StRtypeEx;
            OpBeq:                   return StBeqEx;
            OpBne:                   return StBneEx;
            OpAddi:                  return StAddiEx;
            OpAndi:                  return StAndiEx;
            OpOri:                   return StOriEx;
            OpSlti:                  return StSltiEx;
            OpJ:                     return StJex;
            default:                 return StError;
        endcase
    endfunction

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
               (funct == FnOr)  || (funct == FnSlt);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] funct);
        case (funct)
            FnSub:   return AluSub;
            FnAnd:   return AluAnd;
            FnOr:    return AluOr;
            FnSlt:   return AluSlt;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_maindec.sv
// Combinational state-to-control-word decode for the multicycle controller.
module mips_mc_maindec
    import mips_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    // Moore decode; op/funct only select ALU function and load extension.
    always_comb begin
        ctrl            = '0;
        ctrl.alusrcb    = SrcbB;
        ctrl.pcsrc      = PcsrcAluRes;
        ctrl.alucontrol = AluAdd;
        ctrl.lb         = LbWord;
        case (state)
            StFetch: begin
                ctrl.mem_req = 1'b1;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = SrcbFour;
            end
            StDecode: ctrl.alusrcb = SrcbSimmSh;
            StMemAdr: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SrcbSimm;
            end
            StMemRd: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            StMemWb: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                if (op == OpLb) begin
                    ctrl.lb = LbSByte;
                end else if (op == OpLbu) begin
                    ctrl.lb = LbZByte;
                end
            end
            StMemWr: begin
                ctrl.mem_req  = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StRtypeEx: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alucontrol = funct_alu(funct);
            end
            StRtypeWb: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            StBeqEx, StBneEx: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alucontrol = AluSub;
                ctrl.pcsrc      = PcsrcAluOut;
                ctrl.branch     = 1'b1;
                ctrl.bne        = (state == StBneEx);
            end
            StAddiEx: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SrcbSimm;
            end
            StAndiEx: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SrcbZimm;
                ctrl.alucontrol = AluAnd;
            end
            StOriEx: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SrcbZimm;
                ctrl.alucontrol = AluOr;
            end
            StSltiEx: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SrcbSimm;
                ctrl.alucontrol = AluSlt;
            end
            StIwb: ctrl.regwrite = 1'b1;
            StJex: begin
                ctrl.pcsrc   = PcsrcJump;
                ctrl.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS controller: state register, handshake watchdog, enable qualification.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W    = 5,
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [2:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic [1:0]         lb,
    output logic [STATE_W-1:0] state,
    output logic               mem_req,
    output logic               bus_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             bus_err_q, bus_err_d;
    logic             wait_hit;
    ctrl_t            ctrl;

    mips_mc_maindec u_maindec (
        .state (state_q),
        .op    (op),
        .funct (funct),
        .ctrl  (ctrl)
    );

    // Limit is hit on the cycle that would make the count reach WAIT_LIMIT.
    assign wait_hit = (wait_q == CNT_W'(WAIT_LIMIT - 1));

    // Next-state selection, wait counter and sticky error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (wait_hit) begin
                    state_d = StError;
                end
            end
            StDecode: state_d = decode_op(op);
            StMemAdr: state_d = (op == OpSw) ? StMemWr : StMemRd;
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (wait_hit) begin
                    state_d = StError;
                end
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                end else if (wait_hit) begin
                    state_d = StError;
                end
            end
            StRtypeEx: state_d = funct_legal(funct) ? StRtypeWb : StError;
            StAddiEx, StAndiEx, StOriEx, StSltiEx: state_d = StIwb;
            StMemWb, StRtypeWb, StBeqEx, StBneEx, StIwb, StJex: state_d = StFetch;
            StError: state_d = StError;
            default: state_d = StFetch;
        endcase

        // Non-handshake states and every acknowledge leave the counter at zero.
        wait_d    = (ctrl.mem_req && !mem_ready) ? wait_q + CNT_W'(1) : '0;
        bus_err_d = bus_err_q | (state_d == StError);
    end

    // State, counter and error flag registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    // FETCH pcen waits for the acknowledge; branches take the ALU zero flag.
    assign pcen       = (ctrl.pcwrite & (~ctrl.mem_req | mem_ready)) |
                        (ctrl.branch & (zero ^ ctrl.bne));
    assign irwrite    = ctrl.irwrite & mem_ready;
    assign memwrite   = ctrl.memwrite & mem_ready;
    assign regwrite   = ctrl.regwrite;
    assign iord       = ctrl.iord;
    assign memtoreg   = ctrl.memtoreg;
    assign regdst     = ctrl.regdst;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign alucontrol = ctrl.alucontrol;
    assign lb         = ctrl.lb;
    assign mem_req    = ctrl.mem_req;
    assign bus_err    = bus_err_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expectations queued by stimulus, checked by monitor.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [2:0] alusrcb, alucontrol;
    logic [1:0] pcsrc, lb;
    logic [4:0] state;
    logic       mem_req, bus_err;

    // Enable vector order: {pcen, irwrite, memwrite, regwrite, mem_req}
    localparam logic [4:0] EnFr  = 5'b11001;
    localparam logic [4:0] EnReq = 5'b00001;
    localparam logic [4:0] EnNo  = 5'b00000;
    localparam logic [4:0] EnRw  = 5'b00010;
    localparam logic [4:0] EnPc  = 5'b10000;
    localparam logic [4:0] EnWr  = 5'b00101;

    typedef struct {
        string      tag;
        logic [4:0] st;
        logic [4:0] en;
        logic       err;
        int         alu;
        int         pcs;
        int         srcb;
        int         lbv;
        int         mtr;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    string      tag = "init";
    logic [5:0] n_op = '0;
    logic [5:0] n_funct = '0;
    logic       n_zero = 1'b0;

    mips_mc_ctrl #(
        .STATE_W    (5),
        .WAIT_LIMIT (15),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .lb         (lb),
        .state      (state),
        .mem_req    (mem_req),
        .bus_err    (bus_err)
    );

    initial forever #5 clk = ~clk;

    // Instruction fields applied from the next cycle onward.
    task automatic ins(input logic [5:0] o, input logic [5:0] f, input logic z);
        n_op    = o;
        n_funct = f;
        n_zero  = z;
    endtask

    task automatic drive(input logic rst, input logic rdy);
        @(negedge clk);
        reset     = rst;
        mem_ready = rdy;
        op        = n_op;
        funct     = n_funct;
        zero      = n_zero;
    endtask

    // One clock cycle of stimulus plus the outputs required during it (-1 = not checked).
    task automatic cyc(input logic rst, input logic rdy, input logic [4:0] st,
                       input logic [4:0] en, input logic err, input int alu, input int pcs,
                       input int srcb, input int lbv, input int mtr);
        exp_t e;
        drive(rst, rdy);
        e.tag  = tag;
        e.st   = st;
        e.en   = en;
        e.err  = err;
        e.alu  = alu;
        e.pcs  = pcs;
        e.srcb = srcb;
        e.lbv  = lbv;
        e.mtr  = mtr;
        sb.push_back(e);
    endtask

    task automatic c(input logic rdy, input logic [4:0] st, input logic [4:0] en);
        cyc(1'b0, rdy, st, en, 1'b0, -1, -1, -1, -1, -1);
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                bad = (state !== e.st) ||
                      ({pcen, irwrite, memwrite, regwrite, mem_req} !== e.en) ||
                      (bus_err !== e.err) ||
                      (e.alu  >= 0 && alucontrol !== e.alu[2:0]) ||
                      (e.pcs  >= 0 && pcsrc      !== e.pcs[1:0]) ||
                      (e.srcb >= 0 && alusrcb    !== e.srcb[2:0]) ||
                      (e.lbv  >= 0 && lb         !== e.lbv[1:0]) ||
                      (e.mtr  >= 0 && memtoreg   !== e.mtr[0]);
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL %s @%0t: got state=%0d en=%b err=%b alu=%b pcsrc=%b srcb=%b lb=%b mtr=%b; want state=%0d en=%b err=%b alu=%0d pcsrc=%0d srcb=%0d lb=%0d mtr=%0d",
                             e.tag, $time, state, {pcen, irwrite, memwrite, regwrite, mem_req},
                             bus_err, alucontrol, pcsrc, alusrcb, lb, memtoreg,
                             e.st, e.en, e.err, e.alu, e.pcs, e.srcb, e.lbv, e.mtr);
                end
            end
        end
    end

    initial begin
        // Reset with ready high: FETCH decode, gated enables follow mem_ready.
        tag = "reset";
        ins(6'b000000, 6'b100000, 1'b0);
        drive(1'b1, 1'b1);
        cyc(1'b1, 1'b1, 5'd0, EnFr, 1'b0, 2, 0, 1, -1, -1);

        tag = "rtype_add";
        cyc(1'b0, 1'b1, 5'd0, EnFr, 1'b0, 2, 0, 1, -1, -1);
        cyc(1'b0, 1'b1, 5'd1, EnNo, 1'b0, 2, -1, 3, -1, -1);
        cyc(1'b0, 1'b1, 5'd6, EnNo, 1'b0, 2, -1, 0, -1, -1);
        cyc(1'b0, 1'b1, 5'd7, EnRw, 1'b0, -1, -1, -1, -1, 0);

        // lbu: 3 wait cycles in FETCH, 2 in MEMRD, 10 cycles total.
        tag = "lbu";
        ins(6'b100100, 6'b000000, 1'b0);
        repeat (3) c(1'b0, 5'd0, EnReq);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd2, EnNo, 1'b0, 2, -1, 2, -1, -1);
        repeat (2) c(1'b0, 5'd3, EnReq);
        c(1'b1, 5'd3, EnReq);
        cyc(1'b0, 1'b1, 5'd4, EnRw, 1'b0, -1, -1, -1, 2, 1);

        tag = "bne_taken";
        ins(6'b000101, 6'b000000, 1'b0);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd9, EnPc, 1'b0, 6, 1, 0, -1, -1);

        tag = "bne_not_taken";
        ins(6'b000101, 6'b000000, 1'b1);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd9, EnNo, 1'b0, 6, 1, 0, -1, -1);

        tag = "beq_taken";
        ins(6'b000100, 6'b000000, 1'b1);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd8, EnPc, 1'b0, 6, 1, 0, -1, -1);

        // sw: memwrite only on the acknowledged MEMWR cycle.
        tag = "sw";
        ins(6'b101011, 6'b000000, 1'b0);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd2, EnNo, 1'b0, 2, -1, 2, -1, -1);
        c(1'b0, 5'd5, EnReq);
        c(1'b1, 5'd5, EnWr);

        tag = "andi";
        ins(6'b001100, 6'b000000, 1'b0);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd11, EnNo, 1'b0, 0, -1, 4, -1, -1);
        c(1'b1, 5'd14, EnRw);

        tag = "slti";
        ins(6'b001010, 6'b000000, 1'b0);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd13, EnNo, 1'b0, 7, -1, 2, -1, -1);
        c(1'b1, 5'd14, EnRw);

        tag = "jump";
        ins(6'b000010, 6'b000000, 1'b0);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd15, EnPc, 1'b0, -1, 2, -1, -1, -1);

        // Illegal opcode: DECODE -> ERROR, sticky until reset.
        tag = "illegal_op";
        ins(6'b111111, 6'b000000, 1'b0);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd31, EnNo, 1'b1, -1, -1, -1, -1, -1);
        cyc(1'b0, 1'b1, 5'd31, EnNo, 1'b1, -1, -1, -1, -1, -1);
        cyc(1'b1, 1'b1, 5'd31, EnNo, 1'b1, -1, -1, -1, -1, -1);

        // Illegal funct: RTYPEEX -> ERROR.
        tag = "illegal_funct";
        ins(6'b000000, 6'b000001, 1'b0);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        c(1'b1, 5'd6, EnNo);
        cyc(1'b0, 1'b1, 5'd31, EnNo, 1'b1, -1, -1, -1, -1, -1);
        cyc(1'b1, 1'b1, 5'd31, EnNo, 1'b1, -1, -1, -1, -1, -1);

        // Ready arriving on the 15th waiting cycle still succeeds.
        tag = "wait_boundary";
        ins(6'b000000, 6'b100010, 1'b0);
        repeat (14) c(1'b0, 5'd0, EnReq);
        c(1'b1, 5'd0, EnFr);
        c(1'b1, 5'd1, EnNo);
        cyc(1'b0, 1'b1, 5'd6, EnNo, 1'b0, 6, -1, 0, -1, -1);
        c(1'b1, 5'd7, EnRw);

        // 15 unacknowledged cycles -> ERROR; ready there is ignored; reset recovers.
        tag = "watchdog";
        repeat (15) c(1'b0, 5'd0, EnReq);
        cyc(1'b0, 1'b0, 5'd31, EnNo, 1'b1, -1, -1, -1, -1, -1);
        cyc(1'b0, 1'b1, 5'd31, EnNo, 1'b1, -1, -1, -1, -1, -1);
        cyc(1'b1, 1'b0, 5'd31, EnNo, 1'b1, -1, -1, -1, -1, -1);
        c(1'b0, 5'd0, EnReq);
        c(1'b1, 5'd0, EnFr);

        @(negedge clk);
        #5;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
